// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer: turns bus handshakes and hazard flags into hold/bubble commands per pipeline register.
// Optional build macro PIPE_CTRL_PERF_EN adds wrapping istall/dstall/redirect event counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_instr,
  input  logic        dreq_valid,
  input  logic        dresp_data_ok,
  input  logic        load_use,
  input  logic        redirect,
  output logic        ireq_valid,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        pc_stall,
  output logic        f_stall,
  output logic        d_stall,
  output logic        e_stall,
  output logic        f_flush,
  output logic        d_flush,
  output logic        e_flush,
  output logic        m_flush
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] istall_cnt,
  output logic [31:0] dstall_cnt,
  output logic [31:0] redirect_cnt
`endif
);

  typedef enum logic {
    S_REQ = 1'b0,
    S_BUF = 1'b1
  } fetch_state_t;

  fetch_state_t state, state_nxt;
  logic [31:0]  ibuf;
  logic         istall;
  logic         dstall;
  logic         fire_dstall;
  logic         fire_redirect;
  logic         fire_istall;

  always_comb begin
    istall = (state == S_REQ) && !iresp_data_ok;
    dstall = dreq_valid && !dresp_data_ok;
  end

  // Priority chain: earlier hazards override later ones, unlisted outputs stay 0.
  always_comb begin
    pc_stall      = 1'b0;
    f_stall       = 1'b0;
    d_stall       = 1'b0;
    e_stall       = 1'b0;
    f_flush       = 1'b0;
    d_flush       = 1'b0;
    e_flush       = 1'b0;
    m_flush       = 1'b0;
    fire_dstall   = 1'b0;
    fire_redirect = 1'b0;
    fire_istall   = 1'b0;
    if (reset) begin
      pc_stall = 1'b1;
      f_flush  = 1'b1;
      d_flush  = 1'b1;
      e_flush  = 1'b1;
      m_flush  = 1'b1;
    end else if (dstall) begin
      pc_stall    = 1'b1;
      f_stall     = 1'b1;
      d_stall     = 1'b1;
      e_stall     = 1'b1;
      m_flush     = 1'b1;
      fire_dstall = 1'b1;
    end else if (redirect && istall) begin
      // Branch must wait in execute for its target fetch; bubble ereg so it is not duplicated.
      pc_stall = 1'b1;
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_flush  = 1'b1;
    end else if (redirect) begin
      f_flush       = 1'b1;
      d_flush       = 1'b1;
      fire_redirect = 1'b1;
    end else if (load_use) begin
      pc_stall = 1'b1;
      f_stall  = 1'b1;
      d_flush  = 1'b1;
    end else if (istall) begin
      pc_stall    = 1'b1;
      f_flush     = 1'b1;
      fire_istall = 1'b1;
    end
  end

  always_comb begin
    ireq_valid  = 1'b0;
    instr_valid = 1'b0;
    instr       = iresp_instr;
    state_nxt   = state;
    case (state)
      S_REQ: begin
        ireq_valid  = !reset;
        instr_valid = iresp_data_ok;
        instr       = iresp_instr;
        // Fetch landed while PC is held: park it so it is not requested again.
        if (iresp_data_ok && pc_stall) begin
          state_nxt = S_BUF;
        end
      end
      S_BUF: begin
        instr_valid = 1'b1;
        instr       = ibuf;
        if (!pc_stall) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
      ibuf  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == S_REQ && state_nxt == S_BUF) begin
        ibuf <= iresp_instr;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      istall_cnt   <= 32'h0;
      dstall_cnt   <= 32'h0;
      redirect_cnt <= 32'h0;
    end else begin
      if (fire_istall) begin
        istall_cnt <= istall_cnt + 32'd1;
      end
      if (fire_dstall) begin
        dstall_cnt <= dstall_cnt + 32'd1;
      end
      if (fire_redirect) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_fire;
  always_comb begin
    unused_fire = fire_dstall ^ fire_redirect ^ fire_istall;
  end
`endif

endmodule
